// File: rtl/cnt_cmp_pwm.sv
// -----------------------------------------------------------------------------
// cnt_cmp_pwm
//
// Compare/PWM stage placed directly after a free-running up counter. It
// samples the counter value and produces a PWM waveform, a one-cycle
// compare-match pulse, a one-cycle wrap pulse and a sticky interrupt flag.
//
// The compare threshold is double-buffered. Software writes a shadow
// register, and the value moves into the active register only at the counter
// wrap. This keeps the duty cycle from glitching in the middle of a period.
//
// Parameters:
//   WIDTH    - width of cnt_i and of the compare registers (max = 2^WIDTH-1)
//   RST_CMP  - active/shadow compare value after reset
//
// Ports:
//   clk_i      in   clock, rising-edge active
//   rst_i      in   asynchronous reset, active-high
//   cnt_i      in   upstream count value (may stall, advance by 1 or jump)
//   cmp_i      in   new compare value
//   cmp_wr_i   in   single-cycle write strobe for cmp_i
//   irq_clr_i  in   clears irq_o (a simultaneous match wins)
//   pwm_o      out  high while count < effective compare (registered)
//   match_o    out  one-cycle pulse on a new count equal to the effective compare
//   wrap_o     out  one-cycle pulse on a MAX -> 0 counter transition
//   irq_o      out  sticky match flag
//   cmp_act_o  out  active compare value
//   pending_o  out  shadow holds a value not yet moved to the active register
// -----------------------------------------------------------------------------
module cnt_cmp_pwm #(
  parameter int WIDTH   = 4,
  parameter int RST_CMP = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] cmp_i,
  input  logic             cmp_wr_i,
  input  logic             irq_clr_i,
  output logic             pwm_o,
  output logic             match_o,
  output logic             wrap_o,
  output logic             irq_o,
  output logic [WIDTH-1:0] cmp_act_o,
  output logic             pending_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_CMP);

  // Sampled counter history
  logic [WIDTH-1:0] cnt_reg;
  logic             valid_reg;

  // Compare register pair
  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] act_reg;
  logic             pending_reg;

  // Registered outputs
  logic             pwm_reg;
  logic             match_reg;
  logic             wrap_reg;
  logic             irq_reg;

  // Combinational decode of the current sample
  logic             new_cnt;
  logic             wrap;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] eff;
  logic             match_next;

  always_comb begin
    // The first sample after reset has no history, so it always counts as new.
    new_cnt = !valid_reg || (cnt_i != cnt_reg);

    // Only a genuine MAX -> 0 step is a wrap; any other jump to 0 is not.
    wrap = valid_reg && (cnt_reg == CNT_MAX) && (cnt_i == '0);

    // Value that the active register takes at a wrap. A write landing in the
    // wrap cycle itself bypasses the shadow and takes effect immediately.
    if (cmp_wr_i) begin
      load_val = cmp_i;
    end else if (pending_reg) begin
      load_val = shadow_reg;
    end else begin
      load_val = act_reg;
    end

    // In the wrap cycle the incoming threshold already applies, so count 0
    // of the new period is compared against the new value.
    eff = wrap ? load_val : act_reg;

    match_next = new_cnt && (cnt_i == eff);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
      shadow_reg  <= RST_VAL;
      act_reg     <= RST_VAL;
      pending_reg <= 1'b0;
      pwm_reg     <= 1'b0;
      match_reg   <= 1'b0;
      wrap_reg    <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      cnt_reg   <= cnt_i;
      valid_reg <= 1'b1;

      if (wrap) begin
        act_reg     <= load_val;
        pending_reg <= 1'b0;
        if (cmp_wr_i) begin
          shadow_reg <= cmp_i;
        end
      end else if (cmp_wr_i) begin
        // Last write before the wrap wins.
        shadow_reg  <= cmp_i;
        pending_reg <= 1'b1;
      end

      pwm_reg   <= (cnt_i < eff);
      match_reg <= match_next;
      wrap_reg  <= wrap;

      // A set and a clear in the same cycle leave the flag set.
      if (match_next) begin
        irq_reg <= 1'b1;
      end else if (irq_clr_i) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign pwm_o     = pwm_reg;
  assign match_o   = match_reg;
  assign wrap_o    = wrap_reg;
  assign irq_o     = irq_reg;
  assign cmp_act_o = act_reg;
  assign pending_o = pending_reg;

endmodule

// File: tb/tb_cnt_cmp_pwm.sv
// -----------------------------------------------------------------------------
// tb_cnt_cmp_pwm
//
// Testbench for cnt_cmp_pwm. It runs a directed sequence followed by a
// randomized sequence. Every cycle, all outputs are compared against a
// behavioural reference model of the compare/PWM rules.
// -----------------------------------------------------------------------------
module tb_cnt_cmp_pwm;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;
  localparam int RST = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] cnt_i;
  logic [W-1:0] cmp_i;
  logic         cmp_wr_i;
  logic         irq_clr_i;
  logic         pwm_o;
  logic         match_o;
  logic         wrap_o;
  logic         irq_o;
  logic [W-1:0] cmp_act_o;
  logic         pending_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state (plain integers)
  int  m_prev;
  bit  m_have_prev;
  int  m_active;
  int  m_shadow;
  bit  m_pending;
  bit  m_irq;
  // Expected registered outputs
  bit  e_pwm, e_match, e_wrap;

  int  cur;  // last count value driven

  cnt_cmp_pwm #(.WIDTH(W), .RST_CMP(RST)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cnt_i     (cnt_i),
    .cmp_i     (cmp_i),
    .cmp_wr_i  (cmp_wr_i),
    .irq_clr_i (irq_clr_i),
    .pwm_o     (pwm_o),
    .match_o   (match_o),
    .wrap_o    (wrap_o),
    .irq_o     (irq_o),
    .cmp_act_o (cmp_act_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
      end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pwm"},     32'(pwm_o),     32'(e_pwm));
    chk({tag, ".match"},   32'(match_o),   32'(e_match));
    chk({tag, ".wrap"},    32'(wrap_o),    32'(e_wrap));
    chk({tag, ".irq"},     32'(irq_o),     32'(m_irq));
    chk({tag, ".cmp_act"}, 32'(cmp_act_o), 32'(m_active));
    chk({tag, ".pending"}, 32'(pending_o), 32'(m_pending));
  endtask

  task automatic model_reset();
    m_prev      = 0;
    m_have_prev = 0;
    m_active    = RST;
    m_shadow    = RST;
    m_pending   = 0;
    m_irq       = 0;
    e_pwm       = 0;
    e_match     = 0;
    e_wrap      = 0;
  endtask

  // One clock cycle: drive at a falling edge, let the rising edge register the
  // inputs, then check at the next falling edge. The caller must be at a
  // falling edge when it calls this task.
  task automatic step(input int c, input int cmp, input bit wr, input bit clr, input string tag);
    bit is_new, is_wrap;
    int threshold;
    cnt_i     = W'(c);
    cmp_i     = W'(cmp);
    cmp_wr_i  = wr;
    irq_clr_i = clr;
    cur       = c;

    // Model: a period boundary is only a true MAX -> 0 step of the counter.
    is_new  = !m_have_prev || (c != m_prev);
    is_wrap = m_have_prev && (m_prev == MAX) && (c == 0);
    if (is_wrap) begin
      if (wr) begin
        m_active = cmp;
        m_shadow = cmp;
      end else if (m_pending) begin
        m_active = m_shadow;
      end
      m_pending = 0;
    end else if (wr) begin
      m_shadow  = cmp;
      m_pending = 1;
    end
    threshold   = m_active;  // already updated if this is a wrap
    e_pwm       = (c < threshold);
    e_match     = is_new && (c == threshold);
    e_wrap      = is_wrap;
    if (e_match) m_irq = 1;
    else if (clr) m_irq = 0;
    m_prev      = c;
    m_have_prev = 1;

    @(negedge clk_i);
    chk_all(tag);
  endtask

  // Count from a to b inclusive, with no writes and no clears.
  task automatic run(input int a, input int b, input string tag);
    for (int i = a; i <= b; i++) step(i, 0, 0, 0, tag);
  endtask

  initial begin
    rst_i     = 1'b1;
    cnt_i     = '0;
    cmp_i     = '0;
    cmp_wr_i  = 1'b0;
    irq_clr_i = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Two periods at the reset threshold.
    run(0, 15, "rst_p1");
    run(0, 15, "rst_p2");

    // Count held at 8 for five cycles produces a single match pulse.
    run(0, 7, "hold_pre");
    for (int i = 0; i < 5; i++) step(8, 0, 0, 0, "hold8");
    run(9, 15, "hold_post");
    // A clear that coincides with a match leaves irq set.
    run(0, 7, "clr_pre");
    step(8, 0, 0, 1, "clr_with_match");
    // A clear on its own drops irq.
    step(9, 0, 0, 1, "clr_alone");
    run(10, 15, "clr_post");

    // A write in mid-period waits for the wrap.
    run(0, 4, "wr3_pre");
    step(5, 3, 1, 0, "wr3");
    run(6, 15, "wr3_wait");
    run(0, 15, "wr3_period");

    // A write in the exact wrap cycle takes effect immediately.
    step(0, 12, 1, 0, "wr12_wrap");
    run(1, 15, "wr12_period");

    // Boundary thresholds: 0 and MAX.
    run(0, 3, "c0_pre");
    step(4, 0, 1, 0, "wr0");
    run(5, 15, "c0_wait");
    run(0, 15, "c0_period");
    run(0, 3, "c15_pre");
    step(4, 15, 1, 0, "wr15");
    run(5, 15, "c15_wait");
    run(0, 15, "c15_period");

    // A non-sequential jump to 0 is not a wrap, so the pending write stays pending.
    run(0, 5, "jump_pre");
    step(6, 2, 1, 0, "wr2");
    step(0, 0, 0, 0, "jump0");
    run(1, 15, "jump_post");
    run(0, 3, "jump_period");

    // Asynchronous reset in mid-period while a write is pending.
    step(4, 10, 1, 0, "wr10_pend");
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    // The first sample after reset counts as new.
    step(8, 0, 0, 0, "first_after_rst");
    run(9, 15, "after_rst");

    // Randomized phase: mostly advancing, with stalls, jumps, writes and clears.
    for (int n = 0; n < 400; n++) begin
      int r, nxt;
      r = int'($urandom_range(0, 99));
      if (r < 70)      nxt = (cur + 1) % (MAX + 1);
      else if (r < 90) nxt = cur;
      else             nxt = int'($urandom_range(0, MAX));
      step(nxt, int'($urandom_range(0, MAX)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnt_cmp_pwm.md
Name: cnt_cmp_pwm

Overview:
- Compare/PWM stage directly downstream of the free-running up counter.
- Consumes the counter's count value and produces four outputs: a PWM waveform, a one-cycle compare-match pulse, a one-cycle wrap pulse and a sticky interrupt flag.
- The compare threshold is double-buffered: software writes a shadow register, and hardware moves it into the active register at the counter wrap, so the duty cycle never glitches mid-period.

Parameters:
- WIDTH, 4, bit width of cnt_i and of every compare register; counter max is 2^WIDTH-1.
- RST_CMP, 8, value of the active and shadow compare registers after reset; must fit in WIDTH bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- cnt_i  input  WIDTH  count value from the upstream up counter; may hold for several cycles (stall) or advance by 1.
- cmp_i  input  WIDTH  new compare value.
- cmp_wr_i  input  1  single-cycle write strobe for cmp_i.
- irq_clr_i  input  1  clears irq_o.
- pwm_o  output  1  registered PWM output; high while count < effective compare value.
- match_o  output  1  one-cycle pulse on a new count equal to the effective compare value.
- wrap_o  output  1  one-cycle pulse on a counter wrap.
- irq_o  output  1  sticky match flag.
- cmp_act_o  output  WIDTH  active compare value.
- pending_o  output  1  shadow holds a value not yet transferred to the active register.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - pwm_o=0, match_o=0, wrap_o=0, irq_o=0, pending_o=0.
  - cmp_act_o=RST_CMP, shadow=RST_CMP.
  - Internal cnt_q=0 and valid_q=0.
- Every cycle: cnt_q<=cnt_i and valid_q<=1.
- new_cnt = !valid_q || (cnt_i != cnt_q). The first sample after reset always counts as new.
- wrap = valid_q && cnt_q == 2^WIDTH-1 && cnt_i == 0.
- Shadow write: when cmp_wr_i=1 and no wrap, shadow<=cmp_i and pending<=1. A second write before the wrap overwrites the shadow; the last write wins.
- Transfer on a wrap cycle:
  - If cmp_wr_i=1: active<=cmp_i, shadow<=cmp_i, pending<=0.
  - Else if pending=1: active<=shadow, pending<=0.
  - Else: active is unchanged.
- Effective compare value (eff):
  - In a wrap cycle, eff is the value being loaded into active.
  - Otherwise eff = active.
  - A new threshold therefore applies from count 0 of the new period.
- Registered outputs, all with 1-cycle latency from cnt_i:
  - pwm_o <= (cnt_i < eff), unsigned.
  - match_o <= new_cnt && (cnt_i == eff). A held count pulses only once.
  - wrap_o <= wrap.
- Duty cycle: eff=0 gives a constantly low PWM; eff=2^WIDTH-1 gives a PWM low only while the count is at max. Duty = eff / 2^WIDTH.
- irq_o:
  - Set on the same edge that asserts match_o.
  - Cleared by irq_clr_i.
  - Set and clear in the same cycle: set wins.
- Stalls: a held cnt_i keeps pwm_o steady and produces no new match or wrap pulses.
- Non-sequential jumps in cnt_i (e.g. an upstream reset) are not treated as a wrap. A match still fires if the new value equals eff.
- Reset mid-period: all state returns to reset values immediately, and any pending write is lost.

Test Plan:
- Reset release with the counter running from 0 and RST_CMP=8 -> pwm_o high for counts 0..7 and low for 8..15 (lagging 1 cycle); match_o pulses once per period, the cycle after cnt_i=8; wrap_o pulses the cycle after cnt_i goes 15->0.
- cmp_wr_i with cmp_i=3 at cnt_i=5 -> pending_o=1 and cmp_act_o stays 8 through cnt 15; after the wrap, cmp_act_o=3, pending_o=0, and the next period's pwm_o is high for counts 0..2.
- cmp_wr_i with cmp_i=12 in the exact wrap cycle (cnt_i=0) -> cmp_act_o=12 on the next edge, pending_o stays 0, and pwm_o is high for counts 0..11 of that period.
- Counter held at 8 for 5 cycles -> match_o is a single 1-cycle pulse, irq_o=1 and remains set; irq_clr_i together with a new match in the same cycle -> irq_o stays 1; irq_clr_i alone -> irq_o=0.
- Compare values 0 and 15 -> pwm_o constantly 0 for cmp=0; for cmp=15, pwm_o is 0 only for the cycle after cnt_i=15; match fires at cnt 0 (cmp=0) and at cnt 15 (cmp=15) respectively.
- rst_i asserted mid-period with pending_o=1 -> all outputs return to reset values asynchronously and cmp_act_o=8; after release, the first sample is treated as new (match fires if cnt_i=8).
